// File: rtl/pipe_register_pkg.sv
// Shared definitions for the pipe_register slice: default sizes, count width
// helper and the handshake state labels used when observing an interface.
package pipe_pkg;

  localparam int unsigned DEFAULT_WIDTH  = 8;
  localparam int unsigned DEFAULT_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    STALL
  } hs_state_e;

  function automatic int unsigned count_width(input int unsigned stages);
    return $clog2(stages + 1);
  endfunction

  function automatic hs_state_e hs_state(input logic valid, input logic ready);
    if (!valid) begin
      return IDLE;
    end
    return ready ? XFER : STALL;
  endfunction

endpackage

// File: rtl/pipe_register_if.sv
// Producer/consumer handshake bundle for pipe_register; the slave modport is
// the register chain itself, the master modport is whoever drives it.
interface pipe_register_if #(
  parameter int unsigned WIDTH = pipe_pkg::DEFAULT_WIDTH
) ();

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );

endinterface

// File: rtl/pipe_register_stage.sv
// One valid/data slot of the register chain. The slot accepts from upstream
// whenever it is empty or the slot ahead is also moving.
module pipe_stage #(
  parameter int unsigned      WIDTH       = pipe_pkg::DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  input  logic             rdy_next,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             rdy
);

  assign rdy = !valid || rdy_next;

  // Flush only drops the valid bit; data of an empty slot is left untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= RESET_VALUE;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (rdy) begin
      valid <= src_valid;
      if (src_valid) begin
        data <= src_data;
      end
    end
  end

endmodule

// File: rtl/pipe_register.sv
// STAGES-deep valid/ready register chain with collapsing bubbles and flush.
// Optional occupancy port `count` is built when PIPE_REGISTER_COUNT_EN is defined.
module pipe_register
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned      STAGES      = DEFAULT_STAGES,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  pipe_register_if.slave                    bus
`ifdef PIPE_REGISTER_COUNT_EN
  ,
  output logic [count_width(STAGES)-1:0]    count
`endif
);

  logic [STAGES-1:0] valid;
  logic [WIDTH-1:0]  data [STAGES];
  logic [STAGES:0]   rdy;
  logic              in_xfer;
  logic              out_xfer;

  assign rdy[STAGES]   = bus.out_ready;
  assign bus.in_ready  = rdy[0] && !flush;
  assign in_xfer       = bus.in_valid && bus.in_ready;
  assign out_xfer      = bus.out_valid && bus.out_ready;
  assign bus.out_data  = data[STAGES-1];
  assign bus.out_valid = valid[STAGES-1];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             src_valid;
    logic [WIDTH-1:0] src_data;

    if (i == 0) begin : g_head
      assign src_valid = in_xfer;
      assign src_data  = bus.in_data;
    end else begin : g_body
      assign src_valid = valid[i-1];
      assign src_data  = data[i-1];
    end

    pipe_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .src_valid (src_valid),
      .src_data  (src_data),
      .rdy_next  (rdy[i+1]),
      .valid     (valid[i]),
      .data      (data[i]),
      .rdy       (rdy[i])
    );
  end

`ifdef PIPE_REGISTER_COUNT_EN
  localparam int unsigned CW = count_width(STAGES);

  logic [CW-1:0] cnt_q;

  // Flush wins over a simultaneous output transfer: the chain is empty afterwards.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt_q <= '0;
    end else if (in_xfer && !out_xfer) begin
      cnt_q <= cnt_q + CW'(1);
    end else if (!in_xfer && out_xfer) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign count = cnt_q;
`endif

endmodule

// File: tb/tb_pipe_register.sv
// Scoreboard bench for pipe_register in three sizes, driven from shared stimulus
// and checked against a per-configuration word-position queue model.
module tb_pipe_register;
  import pipe_pkg::*;

  localparam int          NCFG          = 3;
  localparam int          S_T  [NCFG]   = '{2, 1, 4};
  localparam int          W_T  [NCFG]   = '{8, 1, 32};
  localparam logic [31:0] RV_T [NCFG]   = '{32'h0, 32'h1, 32'hDEADBEEF};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;
  bit          checking = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] d;
    int          pos;
  } word_t;

  for (genvar c = 0; c < NCFG; c++) begin : g_cfg
    localparam int          S  = S_T[c];
    localparam int          W  = W_T[c];
    localparam logic [31:0] RV = RV_T[c];

    pipe_register_if #(.WIDTH(W)) bus ();

    assign bus.in_data   = in_data[W-1:0];
    assign bus.in_valid  = in_valid;
    assign bus.out_ready = out_ready;

`ifdef PIPE_REGISTER_COUNT_EN
    logic [count_width(S)-1:0] cnt;
`endif

    pipe_register #(
      .WIDTH       (W),
      .STAGES      (S),
      .RESET_VALUE (RV[W-1:0])
    ) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
`ifdef PIPE_REGISTER_COUNT_EN
      ,
      .count (cnt)
`endif
    );

    // Each accepted word is queued with its current stage; it moves forward one
    // stage per edge unless it would catch up with the word ahead of it.
    word_t       q[$];
    logic [31:0] last_out = RV;

    function automatic bit m_in_ready();
      return ((q.size() < S) || out_ready) && !flush;
    endfunction

    function automatic bit m_out_valid();
      return (q.size() > 0) && (q[0].pos == S - 1);
    endfunction

    always @(posedge clk) begin
      bit ir;
      bit ov;
      ir = m_in_ready();
      ov = m_out_valid();
      if (rst) begin
        q.delete();
        last_out = RV;
      end else if (flush) begin
        q.delete();
      end else begin
        if (ov && out_ready) begin
          void'(q.pop_front());
        end
        for (int k = 0; k < q.size(); k++) begin
          int lim;
          lim = (k == 0) ? S - 1 : q[k-1].pos - 1;
          q[k].pos = (q[k].pos + 1 < lim) ? q[k].pos + 1 : lim;
        end
        if (in_valid && ir) begin
          q.push_back('{d: 32'(in_data[W-1:0]), pos: 0});
        end
        if (m_out_valid()) begin
          last_out = q[0].d;
        end
      end
    end

    always @(negedge clk) begin
      if (checking) begin
        chk($sformatf("cfg%0d in_ready", c), 64'(bus.in_ready), 64'(m_in_ready()));
        chk($sformatf("cfg%0d out_valid", c), 64'(bus.out_valid), 64'(m_out_valid()));
        chk($sformatf("cfg%0d out_data", c), 64'(bus.out_data), 64'(last_out));
        if (hs_state(m_out_valid(), out_ready) == XFER) begin
          chk($sformatf("cfg%0d xfer_word", c), 64'(bus.out_data), 64'(q[0].d));
        end
`ifdef PIPE_REGISTER_COUNT_EN
        chk($sformatf("cfg%0d count", c), 64'(cnt), 64'(q.size()));
`endif
      end
    end
  end

  // Present consecutive words starting at `first`, advancing only when the
  // two-stage configuration accepts one.
  task automatic send_words(input int first, input int n, input bit ordy);
    int  k = 0;
    int  cyc = 0;
    bit  acc;
    in_valid  = 1'b1;
    in_data   = first;
    out_ready = ordy;
    while (k < n && cyc < 50) begin
      @(negedge clk);
      acc = g_cfg[0].bus.in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        k++;
        in_data = first + k;
      end
    end
    in_valid = 1'b0;
    chk("send_budget", 64'(k), 64'(n));
  endtask

  task automatic idle(input int n, input bit ordy);
    in_valid  = 1'b0;
    out_ready = ordy;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // reset and first word
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checking = 1'b1;
    chk("reset out_valid", 64'(g_cfg[0].bus.out_valid), 64'd0);
    chk("reset out_data", 64'(g_cfg[0].bus.out_data), 64'd0);
    rst = 1'b0;
    idle(2, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'd31;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("fill latency early", 64'(g_cfg[0].bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("fill out_valid", 64'(g_cfg[0].bus.out_valid), 64'd1);
    chk("fill out_data", 64'(g_cfg[0].bus.out_data), 64'd31);
    idle(3, 1'b1);

    // streaming
    send_words(1, 20, 1'b1);
    idle(6, 1'b1);

    // backpressure
    send_words(100, 2, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'd102;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("bp in_ready", 64'(g_cfg[0].bus.in_ready), 64'd0);
    chk("bp out_data", 64'(g_cfg[0].bus.out_data), 64'd100);
    send_words(102, 1, 1'b1);
    idle(6, 1'b1);

    // flush
    send_words(12, 2, 1'b0);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'd14;
    @(negedge clk);
    chk("flush in_ready", 64'(g_cfg[0].bus.in_ready), 64'd0);
    chk("flush head", 64'(g_cfg[0].bus.out_data), 64'd12);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush empty", 64'(g_cfg[0].bus.out_valid), 64'd0);
    idle(6, 1'b1);

    // reset mid-stream
    send_words(40, 2, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'd77;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rst out_valid", 64'(g_cfg[0].bus.out_valid), 64'd0);
    chk("rst out_data", 64'(g_cfg[0].bus.out_data), 64'd0);
    idle(6, 1'b1);

    // randomized traffic with varying consumer pressure
    for (int blk = 0; blk < 8; blk++) begin
      int ready_pct;
      ready_pct = $urandom_range(10, 95);
      for (int i = 0; i < 50; i++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_data   = $urandom;
        out_ready = ($urandom_range(0, 99) < ready_pct);
        flush     = ($urandom_range(0, 39) == 0);
        rst       = ($urandom_range(0, 119) == 0);
        @(posedge clk);
        #1;
      end
    end
    flush = 1'b0;
    rst   = 1'b0;
    idle(8, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_register.md
Name: pipe_register

Overview:
Parametrised successor to the team's single enabled/reset register: a chain of STAGES data registers with a valid/ready handshake on each side.
- Bubbles collapse, so throughput is one word per cycle under backpressure.
- Adds a synchronous flush.
- Used between datapath blocks wherever retiming or backpressure tolerance is needed, in place of hand-chained register instances.

Parameters:
WIDTH, 8, data width in bits (>=1)
STAGES, 2, number of register stages (>=1)
RESET_VALUE, 0, value loaded into every data register on reset

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
flush  input  1  clears all stages at the next edge
in_data  input  WIDTH  producer data
in_valid  input  1  producer has data
in_ready  output  1  block accepts in_data this cycle
out_data  output  WIDTH  data of the last stage
out_valid  output  1  last stage holds valid data
out_ready  input  1  consumer accepts out_data this cycle

Behaviour:
- Interface decision: one clock, clk. Reset rst is synchronous and active-high, sampled only on the rising edge of clk.
- Stage indexing: 0 is the input side, STAGES-1 the output side. Each stage i has valid[i] and data[i].
- Reset:
  - All valid[i] are 0 and all data[i] are RESET_VALUE after the edge.
  - Therefore out_valid=0 and out_data=RESET_VALUE.
  - rst has priority over flush and over every handshake. A word in flight at reset is discarded.
- Ready chain (combinational):
  - rdy[STAGES] = out_ready.
  - rdy[i] = !valid[i] || rdy[i+1].
  - in_ready = rdy[0] && !flush.
- Stage update at the edge, when not in rst or flush:
  - If rdy[i]: valid[i] <= src_valid, where src_valid is in_valid && in_ready for stage 0, and valid[i-1] otherwise.
  - data[i] loads src_data only when src_valid=1. Otherwise data[i] holds its value. An empty stage's data is don't-care but stable.
  - If !rdy[i]: the stage holds.
- Transfers:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
- Latency: a word accepted at edge N is first visible on out_data after edge N+STAGES-1, with out_valid=1 from that point. The minimum is STAGES cycles from in_valid to out_valid.
- Full: all valid[i]=1 and out_ready=0 gives in_ready=0. With out_ready=1 and all stages full, input and output transfers both occur in the same cycle at full rate.
- Empty: out_valid=0. out_ready is ignored.
- Flush:
  - in_ready is forced 0.
  - An output transfer in the flush cycle still completes; the consumer owns that word.
  - At the edge all valid[i] <= 0. Data registers are not reset by flush.
- Ordering: words exit in acceptance order. No duplication, no loss except by rst or flush.
- Data stability: out_data and out_valid are register outputs. While out_valid=1 && out_ready=0 both are held stable.

Optional Feature:
PIPE_REGISTER_COUNT_EN
- Defined:
  - Adds output port count, width $clog2(STAGES+1), equal to the number of valid stages.
  - Driven from a registered counter: +1 on input transfer only, -1 on output transfer only, unchanged on both or neither.
  - Reset and flush set it to 0. On a flush cycle that also has an output transfer the result is 0.
  - count always equals the popcount of valid[].
- Undefined: the port and the counter are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - default WIDTH and STAGES constants;
  - the count-width function (clog2 of STAGES+1);
  - the handshake state encoding used by benches (IDLE, XFER, STALL).
- Sub-module pipe_stage: one valid/data slot with rst, flush, src_valid, src_data, rdy_next, producing valid, data and rdy. It is instantiated STAGES times via generate, and the top level only wires the ready/valid chain.

Test Plan:
1. Reset and fill: rst=1 for 2 cycles, then release. out_valid=0 and out_data=0 are required. Send 8'd31 at edge 5 with out_ready=1 and STAGES=2: out_valid=1 and out_data=31 after edge 6.
2. Streaming: drive 1,2,...,20 back-to-back with out_ready=1. Required: in_ready stays 1, output is 1..20 contiguous, one per cycle.
3. Backpressure: out_ready=0 while sending 100,101,102. Required: in_ready drops to 0 after 2 accepts; out_data holds 100. Raising out_ready yields 100 then 101, and 102 is accepted once space frees.
4. Flush: fill with 12 and 13, assert flush for 1 cycle with out_ready=1. Required: 12 is consumed in the flush cycle and in_ready=0 during flush. Next cycle out_valid=0, and 13 never appears.
5. Reset mid-stream: with 2 words in flight and in_valid=1, pulse rst. Required: the next cycle has out_valid=0 and out_data=RESET_VALUE, and nothing accepted in the rst cycle emerges.
6. Configurations: repeat 2 and 3 with STAGES=1 WIDTH=1 and STAGES=4 WIDTH=32. With PIPE_REGISTER_COUNT_EN, check count tracks 0→2→0 across scenarios 3 and 4.
